// File: rtl/vga_timing_pkg.sv
// Shared raster constants (640x480@60) and the helpers that derive
// axis totals and blanking lengths from porch/sync/active widths.
package vga_timing_pkg;

    localparam int unsigned CNT_W = 10;

    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned H_FP_DEF     = 16;
    localparam int unsigned H_SYNC_DEF   = 96;
    localparam int unsigned H_BP_DEF     = 48;

    localparam int unsigned V_ACTIVE_DEF = 480;
    localparam int unsigned V_FP_DEF     = 10;
    localparam int unsigned V_SYNC_DEF   = 2;
    localparam int unsigned V_BP_DEF     = 33;

    typedef struct packed {
        logic       hsync;
        logic       vsync;
        logic       active;
        logic       newline;
        logic       frame;
        logic [7:0] line;
    } vga_out_t;

    function automatic int unsigned axis_blank(input int unsigned fp,
                                               input int unsigned sync,
                                               input int unsigned bp);
        return fp + sync + bp;
    endfunction

    function automatic int unsigned axis_total(input int unsigned active,
                                               input int unsigned fp,
                                               input int unsigned sync,
                                               input int unsigned bp);
        return axis_blank(fp, sync, bp) + active;
    endfunction

    // Reader row index: rows below the blanking offset, optionally line-doubled.
    function automatic logic [7:0] row_index(input logic [CNT_W-1:0] vc,
                                             input logic [CNT_W-1:0] vb,
                                             input int unsigned      shift);
        return 8'((vc - vb) >> shift);
    endfunction

    function automatic vga_out_t vga_out_reset(input logic sync_pol);
        vga_out_t r;
        r.hsync   = ~sync_pol;
        r.vsync   = ~sync_pol;
        r.active  = 1'b0;
        r.newline = 1'b0;
        r.frame   = 1'b0;
        r.line    = 8'd0;
        return r;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrapping position counter with sync/active region flags.
// Used once per clock for H and once per line (H wrap) for V.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned FP     = H_FP_DEF,
    parameter int unsigned SYNC   = H_SYNC_DEF,
    parameter int unsigned BP     = H_BP_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             wrap,
    output logic             in_sync,
    output logic             in_active
);

    localparam int unsigned      TOTAL      = axis_total(ACTIVE, FP, SYNC, BP);
    localparam int unsigned      BLANK      = axis_blank(FP, SYNC, BP);
    localparam logic [CNT_W-1:0] LAST       = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] SYNC_START = CNT_W'(FP);
    localparam logic [CNT_W-1:0] SYNC_END   = CNT_W'(FP + SYNC);
    localparam logic [CNT_W-1:0] ACT_START  = CNT_W'(BLANK);

    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] count_q;

    assign wrap      = inc && (count_q == LAST);
    assign in_sync   = (count_q >= SYNC_START) && (count_q < SYNC_END);
    assign in_active = (count_q >= ACT_START);
    assign count     = count_q;

    // Next position: hold, step, or wrap to zero.
    always_comb begin
        count_d = count_q;
        if (inc) begin
            if (wrap) begin
                count_d = {CNT_W{1'b0}};
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end else begin
            count_d = count_q;
        end
    end

    // Position register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= {CNT_W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/vga_timing.sv
// Free-running raster timing generator: syncs, display enable, and the
// newline/line/advance strobes feeding the pixel data reader.
module vga_timing
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned H_FP     = H_FP_DEF,
    parameter int unsigned H_SYNC   = H_SYNC_DEF,
    parameter int unsigned H_BP     = H_BP_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned V_FP     = V_FP_DEF,
    parameter int unsigned V_SYNC   = V_SYNC_DEF,
    parameter int unsigned V_BP     = V_BP_DEF,
    parameter int unsigned NL_LEAD  = 4,
    parameter int unsigned V_SHIFT  = 1,
    parameter logic        SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       hsync,
    output logic       vsync,
    output logic       active,
    output logic       advance,
    output logic       newline,
    output logic [7:0] line,
    output logic       frame
);

    localparam int unsigned      HB    = axis_blank(H_FP, H_SYNC, H_BP);
    localparam int unsigned      VB    = axis_blank(V_FP, V_SYNC, V_BP);
    localparam logic [CNT_W-1:0] NL_HC = CNT_W'(HB - NL_LEAD);
    localparam logic [CNT_W-1:0] VB_C  = CNT_W'(VB);

    if ((NL_LEAD < 1) || (NL_LEAD > H_BP)) begin : g_nl_lead_chk
        $error("vga_timing: NL_LEAD must lie in 1..H_BP");
    end

    logic [CNT_W-1:0] hc_s;
    logic [CNT_W-1:0] vc_s;
    logic             h_wrap_s;
    logic             v_wrap_unused_s;
    logic             h_sync_s;
    logic             v_sync_s;
    logic             h_act_s;
    logic             v_act_s;
    vga_out_t         out_d;
    vga_out_t         out_q;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP)
    ) u_h (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc       (1'b1),
        .count     (hc_s),
        .wrap      (h_wrap_s),
        .in_sync   (h_sync_s),
        .in_active (h_act_s)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP)
    ) u_v (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc       (h_wrap_s),
        .count     (vc_s),
        .wrap      (v_wrap_unused_s),
        .in_sync   (v_sync_s),
        .in_active (v_act_s)
    );

    // Decode the current position; line only moves when newline fires.
    always_comb begin
        out_d         = out_q;
        out_d.hsync   = h_sync_s ? SYNC_POL : ~SYNC_POL;
        out_d.vsync   = v_sync_s ? SYNC_POL : ~SYNC_POL;
        out_d.active  = h_act_s && v_act_s;
        out_d.newline = (hc_s == NL_HC) && v_act_s;
        out_d.frame   = (hc_s == {CNT_W{1'b0}}) && (vc_s == {CNT_W{1'b0}});
        if (out_d.newline) begin
            out_d.line = row_index(vc_s, VB_C, V_SHIFT);
        end else begin
            out_d.line = out_q.line;
        end
    end

    // Output register; every output is this one-cycle-late decode.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q <= vga_out_reset(SYNC_POL);
        end else begin
            out_q <= out_d;
        end
    end

    assign hsync   = out_q.hsync;
    assign vsync   = out_q.vsync;
    assign active  = out_q.active;
    assign advance = out_q.active;
    assign newline = out_q.newline;
    assign line    = out_q.line;
    assign frame   = out_q.frame;

endmodule

// File: tb/tb_vga_timing.sv
// Self-checking bench for vga_timing using small raster parameters.
module tb_vga_timing;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic       hsync, vsync, active, advance, newline, frame;
    logic [7:0] line;
    logic       hsync2, vsync2, active2, advance2, newline2, frame2;
    logic [7:0] line2;

    int err_cnt = 0;
    int chk_cnt = 0;

    logic [13:0] sb_q[$];
    int          q2[$];

    always #5 clk = ~clk;

    // H 2/3/6/16 -> 27 clocks, HB 11; V 1/1/2/4 -> 8 lines, VB 4
    vga_timing #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(6),
        .V_ACTIVE(4),  .V_FP(1), .V_SYNC(1), .V_BP(2),
        .NL_LEAD(4), .V_SHIFT(0), .SYNC_POL(1'b0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .hsync(hsync), .vsync(vsync), .active(active),
        .advance(advance), .newline(newline), .line(line), .frame(frame)
    );

    // Same H axis; V 8/1/1/2 with line doubling
    vga_timing #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(6),
        .V_ACTIVE(8),  .V_FP(1), .V_SYNC(1), .V_BP(2),
        .NL_LEAD(4), .V_SHIFT(1), .SYNC_POL(1'b0)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .hsync(hsync2), .vsync(vsync2), .active(active2),
        .advance(advance2), .newline(newline2), .line(line2), .frame(frame2)
    );

    task automatic check(input string tag, input int obs, input int exp);
        chk_cnt++;
        if (obs != exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference raster model: pushes the expected output word for each edge.
    initial begin
        int mhc, mvc;
        logic [7:0] mline;
        logic hs, vs, act, nl, fr;
        mhc = 0; mvc = 0; mline = 8'd0;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                mhc = 0; mvc = 0; mline = 8'd0;
                sb_q.push_back({1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0});
            end else begin
                hs  = !((mhc >= 2) && (mhc < 5));
                vs  = !(mvc == 1);
                act = (mhc >= 11) && (mvc >= 4);
                nl  = (mhc == 7) && (mvc >= 4);
                fr  = (mhc == 0) && (mvc == 0);
                if (nl) mline = 8'(mvc - 4);
                sb_q.push_back({hs, vs, act, act, nl, fr, mline});
                if (mhc == 26) begin
                    mhc = 0;
                    mvc = (mvc == 7) ? 0 : mvc + 1;
                end else begin
                    mhc++;
                end
            end
        end
    end

    // Scoreboard compare for the main DUT and line-sequence check for dut2.
    initial begin
        logic [13:0] exp_w;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                exp_w = sb_q.pop_front();
                check("sb_outputs", int'({hsync, vsync, active, advance, newline, frame, line}),
                      int'(exp_w));
            end
            if (rst_n && newline2 && (q2.size() > 0)) begin
                check("vshift_line", int'(line2), q2.pop_front());
            end
        end
    end

    task automatic check_reset_values(input string pfx);
        check({pfx, "hsync"},   int'(hsync),   1);
        check({pfx, "vsync"},   int'(vsync),   1);
        check({pfx, "active"},  int'(active),  0);
        check({pfx, "advance"}, int'(advance), 0);
        check({pfx, "newline"}, int'(newline), 0);
        check({pfx, "frame"},   int'(frame),   0);
        check({pfx, "line"},    int'(line),    0);
    endtask

    // Two frames of spec-level timing measurements, cycle 1 = first edge after reset.
    task automatic run_frame_checks(input string pfx);
        int hs_first, hs_last, hs_cnt, hs_frame, vs_cnt, act_cnt, act_first;
        int nl_cnt, last_nl, fr1, fr2;
        logic prev_act;
        hs_first = -1; hs_last = -1; hs_cnt = 0; hs_frame = 0; vs_cnt = 0;
        act_cnt = 0; act_first = -1; nl_cnt = 0; last_nl = -1000;
        fr1 = -1; fr2 = -1; prev_act = 1'b0;
        for (int k = 1; k <= 432; k++) begin
            @(negedge clk);
            if ((k <= 27) && !hsync) begin
                if (hs_first < 0) hs_first = k;
                hs_last = k;
                hs_cnt++;
            end
            if (k <= 216) begin
                if (!hsync) hs_frame++;
                if (!vsync) vs_cnt++;
                if (active) act_cnt++;
                if (newline) begin
                    check({pfx, "nl_line"}, int'(line), nl_cnt);
                    nl_cnt++;
                end
            end
            if (active && (act_first < 0)) act_first = k;
            if (newline) last_nl = k;
            if (active && !prev_act) check({pfx, "nl_to_advance"}, k - last_nl, 4);
            if (frame) begin
                if (fr1 < 0) fr1 = k;
                else if (fr2 < 0) fr2 = k;
            end
            prev_act = active;
        end
        check({pfx, "hsync_first"}, hs_first, 3);
        check({pfx, "hsync_last"},  hs_last,  5);
        check({pfx, "hsync_width"}, hs_cnt,   3);
        check({pfx, "hsync_per_frame"}, hs_frame, 24);
        check({pfx, "active_first"}, act_first, 4 * 27 + 12);
        check({pfx, "vsync_clocks"}, vs_cnt, 27);
        check({pfx, "active_clocks"}, act_cnt, 64);
        check({pfx, "newline_count"}, nl_cnt, 4);
        check({pfx, "frame_first"}, fr1, 1);
        check({pfx, "frame_second"}, fr2, 217);
    endtask

    initial begin
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_values("rst0_");
        for (int i = 0; i < 8; i++) q2.push_back(i >> 1);
        rst_n = 1'b1;
        run_frame_checks("a_");
        check("vshift_all_seen", q2.size(), 0);

        // Counters reach hc=20, vc=5 (position 155) and get reset on the next edge.
        repeat (155) @(negedge clk);
        check("pre_rst_active", int'(active), 1);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_values("rst_mid_");
        rst_n = 1'b1;
        run_frame_checks("b_");

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
